// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage load/store engine: funct3 access codes,
// FSM state encoding and the default memory timeout.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int TIMEOUT_DEF = 16;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
           ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port between the MEM-stage engine (master)
// and the data memory (slave).
interface mem_access_unit_if #(parameter int AW = 32);

  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_wstrb;
  logic          dmem_ack;
  logic [31:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: builds store strobes/replicated data and extracts and
// extends the load result from the returned memory word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_result
);

  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wstrb = 4'b0000;
    wdata = st_data;
    case (st_funct3)
      F3_B: begin
        wstrb = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        wstrb = 4'b0011 << st_off;
        wdata = {2{st_data[15:0]}};
      end
      F3_W: begin
        wstrb = 4'b1111;
        wdata = st_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = st_data;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign shifted = rdata >> {ld_off, 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = shifted[15:0];

  always_comb begin
    ld_result = 32'h0;
    case (ld_funct3)
      F3_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_result = {24'h0, ld_byte};
      F3_H:    ld_result = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_result = {16'h0, ld_half};
      F3_W:    ld_result = rdata;
      default: ld_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one request/ack transaction per access,
// stalls the pipeline while it is in flight and returns extended load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = 32
)(
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic [3:0]        ctrl_mem,
  input  logic [2:0]        funct3,
  input  logic [AW-1:0]     dm_addr,
  input  logic [31:0]       dm_data,
  mem_access_unit_if.master dmem,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              mem_stall,
  output logic              misalign,
  output logic              bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic        dmwe;
  logic        dmrd;
  logic        access;
  logic        start;
  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;
  logic        unused_ctrl;

  assign dmwe        = ctrl_mem[1];
  assign dmrd        = ctrl_mem[0];
  assign unused_ctrl = ^ctrl_mem[3:2];
  assign access      = dmwe | dmrd;

  // Gated by rstn so every combinational output reads 0 while in reset.
  assign misalign  = rstn & access & is_misaligned(funct3, dm_addr[1:0]);
  assign start     = rstn & access & ~misalign & ~flush;
  assign mem_stall = ((state == IDLE) & start) | (state == BUSY);
  assign ld_valid  = (state == DONE);

  mem_lane_align u_lane_align (
    .st_funct3 (funct3),
    .st_off    (dm_addr[1:0]),
    .st_data   (dm_data),
    .wstrb     (st_wstrb),
    .wdata     (st_wdata),
    .ld_funct3 (lat_f3),
    .ld_off    (lat_off),
    .rdata     (dmem.dmem_rdata),
    .ld_result (ld_ext)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      cnt             <= 8'h0;
      lat_f3          <= 3'b000;
      lat_off         <= 2'b00;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= 32'h0;
      dmem.dmem_wstrb <= 4'b0000;
      ld_data         <= 32'h0;
      bus_err         <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= BUSY;
            cnt             <= 8'h0;
            lat_f3          <= funct3;
            lat_off         <= dm_addr[1:0];
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= dmwe;
            dmem.dmem_addr  <= {dm_addr[AW-1:2], 2'b00};
            dmem.dmem_wdata <= dmwe ? st_wdata : 32'h0;
            dmem.dmem_wstrb <= dmwe ? st_wstrb : 4'b0000;
          end
        end
        BUSY: begin
          // An ack on the timeout cycle wins: data is kept and no error raised.
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            if (!dmem.dmem_we) begin
              ld_data <= ld_ext;
            end
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            dmem.dmem_req <= 1'b0;
            bus_err       <= 1'b1;
            ld_data       <= 32'h0;
            state         <= DONE;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        DONE: begin
          // The held instruction leaves MEM now; never re-issue it.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, randomized
// accesses against a byte-lane reference model, and reset corner cases.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          ackCycle;
    logic        flushIdle;
    logic        flushBusy;
    logic        expMis;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expLd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush;
  logic [3:0]  ctrl_mem;
  logic [2:0]  funct3;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        mem_stall;
  logic        misalign;
  logic        bus_err;

  int          nVec = 0;
  int          nFail = 0;
  logic [31:0] lastLd = 32'h0;
  vec_t        tbl[16];

  always #5 clk = ~clk;

  mem_access_unit_if #(.AW(32)) dmem();

  mem_access_unit #(.TIMEOUT(TO), .AW(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .ctrl_mem  (ctrl_mem),
    .funct3    (funct3),
    .dm_addr   (dm_addr),
    .dm_data   (dm_data),
    .dmem      (dmem),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .mem_stall (mem_stall),
    .misalign  (misalign),
    .bus_err   (bus_err)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  // Reference model, written from the access rules with plain arithmetic.
  function automatic logic refMis(input logic we, input logic rd, input logic [2:0] f3,
                                  input logic [31:0] addr);
    return (we | rd) && ((((f3 == 3'd1) || (f3 == 3'd5)) && (addr % 2 != 0)) ||
                         ((f3 == 3'd2) && (addr % 4 != 0)));
  endfunction

  function automatic logic [3:0] refStrb(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 3 : (f3 == 3'd2) ? 15 : 0;
    return 4'(m << (addr % 4));
  endfunction

  function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (addr % 4))) & 32'hFF;
    h = (w >> (8 * (addr % 4))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t mkVec(input logic we, input logic rd, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] rdata, input int ackCycle,
                                 input logic flushIdle, input logic flushBusy,
                                 input logic expMis, input logic [3:0] expStrb,
                                 input logic [31:0] expWdata, input logic [31:0] expLd);
    vec_t v;
    v.we = we; v.rd = rd; v.f3 = f3; v.addr = addr; v.data = data; v.rdata = rdata;
    v.ackCycle = ackCycle; v.flushIdle = flushIdle; v.flushBusy = flushBusy;
    v.expMis = expMis; v.expStrb = expStrb; v.expWdata = expWdata; v.expLd = expLd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    ctrl_mem = 4'h0;
    funct3   = 3'b000;
    dm_addr  = 32'h0;
    dm_data  = 32'h0;
    flush    = 1'b0;
  endtask

  // Drives one access through IDLE, BUSY and DONE, acking in BUSY cycle ackCycle.
  task automatic applyStimulus(input vec_t v);
    int   busyExp;
    int   stalls;
    logic starts;
    logic expErr;
    logic [31:0] expLd;
    @(negedge clk);
    ctrl_mem = {2'b00, v.we, v.rd};
    funct3   = v.f3;
    dm_addr  = v.addr;
    dm_data  = v.data;
    flush    = v.flushIdle;
    #1;
    checkOutput("misalign", {31'h0, misalign}, {31'h0, v.expMis});
    starts = (v.we | v.rd) & ~v.expMis & ~v.flushIdle;
    checkOutput("stall_idle", {31'h0, mem_stall}, {31'h0, starts});
    if (!starts) begin
      @(negedge clk);
      checkOutput("no_req", {31'h0, dmem.dmem_req}, 32'h0);
      clearInputs();
      return;
    end
    busyExp = (v.ackCycle < TO) ? v.ackCycle + 1 : TO;
    expErr  = (v.ackCycle >= TO);
    stalls  = 1;
    for (int k = 0; k < busyExp; k++) begin
      @(negedge clk);
      if (v.flushBusy) flush = 1'b1;
      if (k == v.ackCycle) begin
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = v.rdata;
      end else begin
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = $urandom;
      end
      #1;
      checkOutput("req_busy", {31'h0, dmem.dmem_req}, 32'h1);
      checkOutput("addr_busy", dmem.dmem_addr, v.addr & 32'hFFFF_FFFC);
      if (k == 0) begin
        checkOutput("we", {31'h0, dmem.dmem_we}, {31'h0, v.we});
        if (v.we) begin
          checkOutput("wstrb", {28'h0, dmem.dmem_wstrb}, {28'h0, v.expStrb});
          checkOutput("wdata", dmem.dmem_wdata, v.expWdata);
        end
      end
      if (mem_stall) stalls++;
    end
    @(negedge clk);
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = $urandom;
    #1;
    expLd = expErr ? 32'h0 : (v.we ? lastLd : v.expLd);
    checkOutput("ld_valid_done", {31'h0, ld_valid}, 32'h1);
    checkOutput("stall_done", {31'h0, mem_stall}, 32'h0);
    checkOutput("req_done", {31'h0, dmem.dmem_req}, 32'h0);
    checkOutput("bus_err", {31'h0, bus_err}, {31'h0, expErr});
    checkOutput("ld_data", ld_data, expLd);
    checkOutput("stall_len", stalls, 1 + busyExp);
    lastLd = expLd;
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("ld_valid_idle", {31'h0, ld_valid}, 32'h0);
    checkOutput("bus_err_idle", {31'h0, bus_err}, 32'h0);
    checkOutput("req_idle", {31'h0, dmem.dmem_req}, 32'h0);
  endtask

  initial begin
    vec_t v;
    logic [2:0] ldCodes[5];
    ldCodes[0] = F3_B; ldCodes[1] = F3_H; ldCodes[2] = F3_W;
    ldCodes[3] = F3_BU; ldCodes[4] = F3_HU;

    clearInputs();
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 32'h0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", {31'h0, dmem.dmem_req}, 32'h0);
    checkOutput("rst_ld_valid", {31'h0, ld_valid}, 32'h0);
    checkOutput("rst_stall", {31'h0, mem_stall}, 32'h0);
    checkOutput("rst_ld_data", ld_data, 32'h0);
    checkOutput("rst_bus_err", {31'h0, bus_err}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    //              we    rd    f3     addr          data          rdata         ack fIdl  fBsy  mis   strb     wdata         ld
    tbl[0]  = mkVec(1'b1, 1'b0, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,         1,  1'b0, 1'b0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mkVec(1'b0, 1'b1, F3_B,  32'h203, 32'h0,        32'h80FFFF7F,  0,  1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hFFFFFF80);
    tbl[2]  = mkVec(1'b0, 1'b1, F3_BU, 32'h203, 32'h0,        32'h80FFFF7F,  1,  1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h00000080);
    tbl[3]  = mkVec(1'b0, 1'b1, F3_H,  32'h202, 32'h0,        32'h80010000,  0,  1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hFFFF8001);
    tbl[4]  = mkVec(1'b1, 1'b0, F3_H,  32'h102, 32'h00001234, 32'h0,         2,  1'b0, 1'b0, 1'b0, 4'b1100, 32'h12341234, 32'h0);
    tbl[5]  = mkVec(1'b0, 1'b1, F3_W,  32'h102, 32'h0,        32'h0,         0,  1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0);
    tbl[6]  = mkVec(1'b0, 1'b1, F3_W,  32'h300, 32'h0,        32'h0,         99, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0);
    tbl[7]  = mkVec(1'b0, 1'b1, F3_W,  32'h304, 32'h0,        32'hCAFEF00D,  TO-1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,      32'hCAFEF00D);
    tbl[8]  = mkVec(1'b1, 1'b0, F3_W,  32'h400, 32'h11111111, 32'h0,         0,  1'b1, 1'b0, 1'b0, 4'b1111, 32'h11111111, 32'h0);
    tbl[9]  = mkVec(1'b0, 1'b1, F3_W,  32'h404, 32'h0,        32'h12345678,  2,  1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h12345678);
    tbl[10] = mkVec(1'b1, 1'b0, F3_B,  32'h101, 32'h000000A5, 32'h0,         0,  1'b0, 1'b0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0);
    tbl[11] = mkVec(1'b0, 1'b1, F3_HU, 32'h206, 32'h0,        32'hF00D0000,  1,  1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000F00D);
    tbl[12] = mkVec(1'b1, 1'b1, F3_W,  32'h010, 32'h11223344, 32'h0,         0,  1'b0, 1'b0, 1'b0, 4'b1111, 32'h11223344, 32'h0);
    tbl[13] = mkVec(1'b1, 1'b0, F3_H,  32'h101, 32'h0000BEEF, 32'h0,         0,  1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0);
    tbl[14] = mkVec(1'b0, 1'b0, F3_W,  32'h103, 32'h0,        32'h0,         0,  1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0);
    tbl[15] = mkVec(1'b0, 1'b1, 3'b011, 32'h500, 32'h0,       32'hFFFFFFFF,  0,  1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0);

    for (int i = 0; i < 16; i++) applyStimulus(tbl[i]);

    for (int i = 0; i < 60; i++) begin
      v.we = ($urandom_range(0, 2) == 0);
      v.rd = !v.we || ($urandom_range(0, 3) == 0);
      v.f3 = v.we ? 3'($urandom_range(0, 2)) : ldCodes[$urandom_range(0, 4)];
      v.addr = ($urandom & 32'h0000_0FFC) |
               (($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom_range(0, 3)));
      v.data      = $urandom;
      v.rdata     = $urandom;
      v.ackCycle  = $urandom_range(0, TO);
      v.flushIdle = ($urandom_range(0, 7) == 0);
      v.flushBusy = ($urandom_range(0, 3) == 0);
      v.expMis    = refMis(v.we, v.rd, v.f3, v.addr);
      v.expStrb   = refStrb(v.f3, v.addr);
      v.expWdata  = refWdata(v.f3, v.data);
      v.expLd     = refLoad(v.f3, v.addr, v.rdata);
      applyStimulus(v);
    end

    applyStimulus(mkVec(1'b0, 1'b1, F3_W, 32'h84, 32'h0, 32'h5A5A5A5A, 0, 1'b0, 1'b0,
                        1'b0, 4'b0000, 32'h0, 32'h5A5A5A5A));

    // Reset pulled in the middle of a load abandons it.
    @(negedge clk);
    ctrl_mem = 4'b0001;
    funct3   = F3_W;
    dm_addr  = 32'h80;
    #1;
    checkOutput("rst_seq_stall", {31'h0, mem_stall}, 32'h1);
    @(negedge clk);
    #1;
    checkOutput("rst_seq_busy", {31'h0, dmem.dmem_req}, 32'h1);
    rstn = 1'b0;
    #1;
    checkOutput("rst_mid_req", {31'h0, dmem.dmem_req}, 32'h0);
    checkOutput("rst_mid_addr", dmem.dmem_addr, 32'h0);
    checkOutput("rst_mid_stall", {31'h0, mem_stall}, 32'h0);
    checkOutput("rst_mid_ld_data", ld_data, 32'h0);
    checkOutput("rst_mid_ld_valid", {31'h0, ld_valid}, 32'h0);
    checkOutput("rst_mid_bus_err", {31'h0, bus_err}, 32'h0);
    @(negedge clk);
    clearInputs();
    rstn   = 1'b1;
    lastLd = 32'h0;
    @(negedge clk);
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem.dmem_ack = 1'b0;
    #1;
    checkOutput("stray_ack_valid", {31'h0, ld_valid}, 32'h0);
    checkOutput("stray_ack_req", {31'h0, dmem.dmem_req}, 32'h0);
    checkOutput("stray_ack_ld", ld_data, 32'h0);
    checkOutput("stray_ack_stall", {31'h0, mem_stall}, 32'h0);

    applyStimulus(mkVec(1'b0, 1'b1, F3_W, 32'h0, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b0,
                        1'b0, 4'b0000, 32'h0, 32'h0BADF00D));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
